// File: rtl/moore_pattern_det.sv
// Moore serial pattern detector: state k is the matched-prefix length, with failure-function fallback.
// Optional saturating detection counter built when MOORE_DET_COUNT_EN is defined.
module moore_pattern_det #(
  parameter int W       = 2,
  parameter int LEN     = 4,
  parameter int CNT_W   = 8,
  parameter bit OVERLAP = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         clr,
  input  logic [W-1:0]                 din,
  input  logic [LEN*W-1:0]             pattern,
  output logic                         aout,
  output logic [$clog2(LEN+1)-1:0]     state_o
`ifdef MOORE_DET_COUNT_EN
  ,
  output logic [CNT_W-1:0]             match_cnt
`endif
);

  localparam int KW = $clog2(LEN+1);
  localparam logic [KW-1:0] K_DET = KW'(LEN);

  logic [KW-1:0]       k_q, k_d, k_next;
  logic                aout_q, aout_d;
  logic [LEN:0][KW-1:0] cand;

  // cand[kc]: next state if currently in state kc. The history is pattern[0..kc-1]
  // followed by din, so only pattern self-comparisons and one din compare are needed.
  always_comb begin : fallback
    logic ok;
    ok   = 1'b0;
    cand = '0;
    for (int kc = 0; kc <= LEN; kc++) begin
      for (int j = 1; j <= LEN; j++) begin
        if (j <= kc + 1) begin
          ok = (din == pattern[(j-1)*W +: W]);
          for (int i = 0; i < j - 1; i++) begin
            if (pattern[(kc+1-j+i)*W +: W] != pattern[i*W +: W]) ok = 1'b0;
          end
          if (ok) cand[kc] = KW'(j);
        end
      end
    end
  end

  always_comb begin
    k_next = cand[k_q];
    if (!OVERLAP && (k_q == K_DET)) k_next = cand[0];
    k_d = k_q;
    if (clr)     k_d = '0;
    else if (en) k_d = k_next;
    aout_d = (k_d == K_DET);
  end

`ifdef MOORE_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && (k_next == K_DET) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  assign match_cnt = cnt_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q    <= '0;
      aout_q <= 1'b0;
`ifdef MOORE_DET_COUNT_EN
      cnt_q  <= '0;
`endif
    end else begin
      k_q    <= k_d;
      aout_q <= aout_d;
`ifdef MOORE_DET_COUNT_EN
      cnt_q  <= cnt_d;
`endif
    end
  end

  assign aout    = aout_q;
  assign state_o = k_q;

endmodule

// File: doc/moore_pattern_det.md
# moore_pattern_det

Parametrised Moore-type serial pattern detector. It accepts one W-bit symbol per enabled clock and tracks how many leading symbols of a programmable LEN-symbol pattern are currently matched. It raises a registered, state-only output when the full pattern has been seen. It is the generalised successor of the team's fixed 2-bit-input, two-state Moore FSM and sits in the same control paths, fed by input-decode logic.

## Interface
- W, 2: symbol width in bits (≥1).
- LEN, 4: pattern length in symbols (≥2).
- CNT_W, 8: match-counter width (≥1).
- OVERLAP, 1: 1 = overlapping detection, 0 = non-overlapping.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- en  input  1  symbol-valid qualifier; when low, state holds.
- clr  input  1  synchronous clear of state and counter; has priority over en.
- din  input  W  incoming symbol, sampled when en=1.
- pattern  input  LEN*W  target pattern; symbol i at bits [i*W +: W]; symbol 0 is received first. Quasi-static.
- aout  output  1  registered Moore output: high while state == LEN.
- state_o  output  $clog2(LEN+1)  current state k (matched-prefix length).
- match_cnt  output  CNT_W  saturating detection count. Present only with MOORE_DET_COUNT_EN.

## Operation
- States S0..S_LEN, encoded as integer k = number of pattern symbols matched. S_LEN is DETECT.
- aout = (k == LEN). It is decoded from the state register only and never depends on din or en.
- Next state when en=1 and clr=0 (from state k):
  - Candidate history is pattern[0..k-1] followed by din.
  - Next k' is the largest j ≤ min(k+1, LEN) such that the last j symbols of that history equal pattern[0..j-1]. This is failure-function fallback.
  - The implementation computes k' combinationally from k, din and pattern; no symbol history register is kept.
- From DETECT:
  - With OVERLAP=1, the same rule applies with k = LEN, so j ≤ LEN and self-overlapping patterns can hold DETECT for consecutive symbols.
  - With OVERLAP=0, the next state is computed as if from S0: k' = 1 if din == pattern[0], else 0.
- en=0: state and counter hold; din is ignored.
- clr=1 at an edge: k ← 0 and match_cnt ← 0, regardless of en.
- reset=1, asynchronous:
  - k = 0, aout = 0, state_o = 0, match_cnt = 0, effective immediately without waiting for a clock.
  - Release is synchronised externally. The first edge after release is a normal edge.
- If pattern changes mid-sequence, the current k is reinterpreted against the new pattern with no special handling. Callers change pattern only while clr is asserted or en is low from S0.

## Timing
- Latency: the edge that samples the final pattern symbol loads k = LEN. aout is high for the following clock cycle (registered, 1-cycle latency, glitch-free).
- aout stays high for exactly one cycle per detection, unless en drops while in DETECT (it then holds high) or overlap keeps k = LEN.
- match_cnt updates on the same edge that loads k = LEN (entry into or re-entry to DETECT), so it is visible in the same cycle aout is high.
- Event priority at an edge: reset (async) > clr > en.

## Configuration
- MOORE_DET_COUNT_EN defined:
  - The match_cnt port and CNT_W-bit counter are built.
  - The counter increments on each edge with en=1, clr=0 and k' = LEN.
  - It saturates at 2^CNT_W−1 and never wraps.
- Undefined: no counter logic and no match_cnt port. All other behaviour is identical.

## Test plan
- W=2, LEN=4, pattern=8'h93 (symbols 3,0,1,2). Stream 3,0,1,2 with en=1 → state_o steps 1,2,3,4; aout high exactly one cycle after the 4th edge; match_cnt=1.
- Same pattern, stream 3,3,0,1,2 → after the second 3, state_o=1 (fallback); detection after the 2 symbol; aout pulses once.
- pattern=8'h11 (symbols 1,0,1,0), stream 1,0,1,0,1,0:
  - OVERLAP=1 → aout pulses after the 4th and 6th symbols, match_cnt=2.
  - OVERLAP=0 → pulses after the 4th only, match_cnt=1.
- pattern=8'h93:
  - Stream 3,0, then en=0 for 5 cycles with din=2, then 1,2 → detection; state_o holds 2 while en=0.
  - Repeat with clr pulsed after 3,0 → no detection; state_o=0.
- Stream 3,0,1, then assert reset between edges → aout, state_o and match_cnt read 0 before the next edge; after release, 3,0,1,2 detects normally.
- CNT_W=2 with macro defined, 5 back-to-back detections of 3,0,1,2 → match_cnt reads 1,2,3,3,3. Without the macro, the build has no match_cnt port.
